// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader and the program memory it feeds.
package prog_loader_pkg;

   localparam int          ADDR_W      = 10;
   localparam int          DATA_W      = 18;
   localparam int          BYTE_W      = 8;
   localparam int          CNT_HI_W    = ADDR_W - BYTE_W;
   localparam int          INSTR_HI_W  = DATA_W - 2 * BYTE_W;
   localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
   localparam int          TIMEOUT_DEF = 1000000;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CNT_HI = 4'd1,
      ST_CNT_LO = 4'd2,
      ST_B0     = 4'd3,
      ST_B1     = 4'd4,
      ST_B2     = 4'd5,
      ST_CHK    = 4'd6,
      ST_DONE   = 4'd7,
      ST_ERR    = 4'd8
   } loader_state_t;

   // True while a frame is being received (the inter-byte timer runs only here).
   function automatic logic in_frame(input loader_state_t s);
      return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERR);
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write/status outputs of the loader.
interface prog_loader_if;
   import prog_loader_pkg::*;

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_waddr;
   logic [DATA_W-1:0] prog_wdata;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output rx_valid, rx_data,
      input  prog_we, prog_waddr, prog_wdata, cpu_rst, busy, done, err
   );

   modport slave (
      input  rx_valid, rx_data,
      output prog_we, prog_waddr, prog_wdata, cpu_rst, busy, done, err
   );

endinterface

// File: rtl/prog_loader_timeout.sv
// Inter-byte idle counter: clears on demand, counts when enabled, flags the LIMIT-th idle cycle.
module prog_loader_timeout #(
   parameter int LIMIT = 1000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] r_cnt;

   // The flag fires on the edge that would complete LIMIT idle cycles.
   assign o_tc = i_en && !i_clr && (r_cnt == W'(LIMIT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Frame parser: SYNC, 10-bit word count, 3-byte instructions, mod-256 checksum; writes program RAM.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [7:0] P_SYNC      = SYNC_BYTE,
   parameter int         TIMEOUT_CYC = TIMEOUT_DEF
) (
   input logic          i_clk,
   input logic          i_rst_n,
   prog_loader_if.slave bus
);

   loader_state_t           r_state;
   logic [ADDR_W-1:0]       r_addr;
   logic [ADDR_W-1:0]       r_cnt;
   logic [7:0]              r_sum;
   logic [INSTR_HI_W-1:0]   r_b0;
   logic [7:0]              r_b1;
   logic                    r_we;
   logic [ADDR_W-1:0]       r_waddr;
   logic [DATA_W-1:0]       r_wdata;
   logic                    r_cpu_rst;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;

   logic                    w_in_frame;
   logic                    w_timeout;
   logic [7:0]              w_sum_next;

   assign w_in_frame = in_frame(r_state);
   assign w_sum_next = r_sum + bus.rx_data;

   prog_loader_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (bus.rx_valid || !w_in_frame),
      .i_en    (w_in_frame),
      .o_tc    (w_timeout)
   );

   // Frame FSM with all outputs registered; a received byte always wins over a timeout.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_sum     <= 8'h00;
         r_b0      <= '0;
         r_b1      <= 8'h00;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_cpu_rst <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (bus.rx_valid) begin
            r_sum <= w_sum_next;
            case (r_state)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (bus.rx_data == P_SYNC) begin
                     r_state   <= ST_CNT_HI;
                     r_done    <= 1'b0;
                     r_err     <= 1'b0;
                     r_busy    <= 1'b1;
                     r_cpu_rst <= 1'b1;
                     r_addr    <= '0;
                     r_sum     <= 8'h00;
                  end else begin
                     r_sum <= r_sum;
                  end
               end
               ST_CNT_HI: begin
                  if (bus.rx_data[7:CNT_HI_W] != '0) begin
                     r_state <= ST_ERR;
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt[ADDR_W-1:BYTE_W] <= bus.rx_data[CNT_HI_W-1:0];
                     r_state                <= ST_CNT_LO;
                  end
               end
               ST_CNT_LO: begin
                  r_cnt[BYTE_W-1:0] <= bus.rx_data;
                  r_state           <= ST_B0;
               end
               ST_B0: begin
                  r_b0    <= bus.rx_data[INSTR_HI_W-1:0];
                  r_state <= ST_B1;
               end
               ST_B1: begin
                  r_b1    <= bus.rx_data;
                  r_state <= ST_B2;
               end
               ST_B2: begin
                  r_we    <= 1'b1;
                  r_waddr <= r_addr;
                  r_wdata <= {r_b0, r_b1, bus.rx_data};
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_state <= (r_addr == r_cnt) ? ST_CHK : ST_B0;
               end
               ST_CHK: begin
                  r_busy <= 1'b0;
                  if (w_sum_next == 8'h00) begin
                     r_state   <= ST_DONE;
                     r_done    <= 1'b1;
                     r_cpu_rst <= 1'b0;
                  end else begin
                     r_state <= ST_ERR;
                     r_err   <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end else if (w_timeout) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
         end else begin
            r_state <= r_state;
         end
      end
   end

   assign bus.prog_we    = r_we;
   assign bus.prog_waddr = r_waddr;
   assign bus.prog_wdata = r_wdata;
   assign bus.cpu_rst    = r_cpu_rst;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, directed corner cases, random frames vs. a frame model.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int TO = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   prog_loader_if bus();

   prog_loader #(.P_SYNC(8'hA5), .TIMEOUT_CYC(TO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [9:0]  a;
      logic [17:0] d;
   } wr_t;

   typedef struct {
      logic [7:0]  b0, b1, b2, chk;
      logic [17:0] exp_d;
      logic        exp_done;
   } vec_t;

   wr_t wq[$];
   wr_t exp_q[$];
   logic exp_done;
   int n_total = 0;
   int n_bad   = 0;

   // Capture every write pulse seen on the memory port.
   always @(negedge clk) begin
      if (bus.prog_we === 1'b1) wq.push_back({bus.prog_waddr, bus.prog_wdata});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference: builds a frame of n random words; expected writes are word i at address i,
   // and the frame succeeds iff the bytes after SYNC sum to 0 mod 256.
   task automatic send_frame(input int n, input bit corrupt, input int maxgap);
      logic [7:0]  bq[$];
      logic [7:0]  sum;
      logic [7:0]  chk;
      logic [17:0] w;
      logic [9:0]  c;
      exp_q.delete();
      wq.delete();
      c = 10'(n - 1);
      bq.push_back({6'd0, c[9:8]});
      bq.push_back(c[7:0]);
      for (int i = 0; i < n; i++) begin
         w = 18'($urandom);
         exp_q.push_back({10'(i), w});
         bq.push_back({6'($urandom), w[17:16]});
         bq.push_back(w[15:8]);
         bq.push_back(w[7:0]);
      end
      sum = 8'h00;
      foreach (bq[i]) sum = sum + bq[i];
      chk = 8'h00 - sum;
      if (corrupt) chk = chk + 8'($urandom_range(1, 255));
      bq.push_back(chk);
      exp_done = !corrupt;
      put(8'hA5);
      foreach (bq[i]) begin
         put(bq[i]);
         if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
   endtask

   task automatic check_frame(input string tag);
      int mism;
      mism = 0;
      check({tag, "_nwr"}, 32'(wq.size()), 32'(exp_q.size()));
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
         if (wq[i] !== exp_q[i]) mism++;
      end
      check({tag, "_wr"}, 32'(mism), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
      check({tag, "_err"}, 32'(bus.err), 32'(!exp_done));
      check({tag, "_cpurst"}, 32'(bus.cpu_rst), 32'(!exp_done));
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"}, 32'(bus.prog_we), 32'd0);
      check({tag, "_waddr"}, 32'(bus.prog_waddr), 32'd0);
      check({tag, "_wdata"}, 32'(bus.prog_wdata), 32'd0);
      check({tag, "_cpurst"}, 32'(bus.cpu_rst), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_err"}, 32'(bus.err), 32'd0);
   endtask

   initial begin
      vec_t vt[5];
      int   k;

      vt[0] = '{8'h03, 8'h12, 8'h34, 8'hB7, 18'h31234, 1'b1};
      vt[1] = '{8'h03, 8'h12, 8'h34, 8'hB8, 18'h31234, 1'b0};
      vt[2] = '{8'hFE, 8'hFF, 8'hFF, 8'h04, 18'h2FFFF, 1'b1};
      vt[3] = '{8'hA5, 8'hA5, 8'hA5, 8'h11, 18'h1A5A5, 1'b1};
      vt[4] = '{8'h00, 8'h00, 8'h00, 8'h01, 18'h00000, 1'b0};

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #2 rst_n = 1'b0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Single-word frames from the table: write latency, address, data, status.
      foreach (vt[i]) begin
         wq.delete();
         put(8'hA5);
         check("vec_busy", 32'(bus.busy), 32'd1);
         put(8'h00);
         put(8'h00);
         put(vt[i].b0);
         put(vt[i].b1);
         put(vt[i].b2);
         check("vec_we_lat", 32'(bus.prog_we), 32'd1);
         check("vec_waddr", 32'(bus.prog_waddr), 32'd0);
         check("vec_wdata", 32'(bus.prog_wdata), 32'(vt[i].exp_d));
         put(vt[i].chk);
         check("vec_we_pulse", 32'(bus.prog_we), 32'd0);
         check("vec_nwr", 32'(wq.size()), 32'd1);
         check("vec_done", 32'(bus.done), 32'(vt[i].exp_done));
         check("vec_err", 32'(bus.err), 32'(!vt[i].exp_done));
         check("vec_cpurst", 32'(bus.cpu_rst), 32'(!vt[i].exp_done));
         check("vec_busy_end", 32'(bus.busy), 32'd0);
         idle($urandom_range(0, 2));
      end

      // Bad upper bits in CNT_HI: immediate error, nothing written, later bytes ignored.
      wq.delete();
      put(8'hA5);
      put(8'h04);
      check("cnthi_err", 32'(bus.err), 32'd1);
      check("cnthi_busy", 32'(bus.busy), 32'd0);
      check("cnthi_cpurst", 32'(bus.cpu_rst), 32'd1);
      check("cnthi_done", 32'(bus.done), 32'd0);
      put(8'h00); put(8'h03); put(8'h12); put(8'h34); put(8'hB7);
      idle(2);
      check("cnthi_nwr", 32'(wq.size()), 32'd0);

      // Stall after B1: error exactly TO cycles after the last strobe.
      wq.delete();
      put(8'hA5); put(8'h00); put(8'h00); put(8'h03); put(8'h12);
      k = 0;
      for (int c = 1; c <= 4 * TO; c++) begin
         @(posedge clk);
         #1;
         if (bus.err === 1'b1) begin
            k = c;
            break;
         end
      end
      check("tmo_cycle", 32'(k), 32'(TO));
      check("tmo_busy", 32'(bus.busy), 32'd0);
      check("tmo_cpurst", 32'(bus.cpu_rst), 32'd1);
      check("tmo_nwr", 32'(wq.size()), 32'd0);
      send_frame(2, 1'b0, 0);
      check_frame("tmo_recover");

      // Reset between B0 and B1 clears outputs at once; orphan bytes are ignored.
      put(8'hA5); put(8'h00); put(8'h00); put(8'h03);
      check("rst_busy_before", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      @(posedge clk);
      #1 rst_n = 1'b1;
      wq.delete();
      put(8'h12); put(8'h34); put(8'hB7);
      idle(2);
      check("rst_orphan_nwr", 32'(wq.size()), 32'd0);
      check("rst_orphan_busy", 32'(bus.busy), 32'd0);
      check("rst_orphan_done", 32'(bus.done), 32'd0);
      send_frame(3, 1'b0, 1);
      check_frame("rst_reload");

      // Full memory image with a byte every cycle.
      send_frame(1024, 1'b0, 0);
      check_frame("full");
      check("full_addr_wrap", 32'(dut.r_addr), 32'd0);

      // Random frames with random gaps and occasional bad checksums.
      for (int f = 0; f < 10; f++) begin
         send_frame($urandom_range(1, 40), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
         check_frame("rnd");
         idle($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
